// File: rtl/adder_4b_struct.sv
// 4-bit unsigned ripple-carry adder built from gate-level full-adder cells,
// with a registered copy of sum/carry and a sticky carry-seen status flag.

module adder_4b_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module adder_4b_struct (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       cout,
  output logic [3:0] sum_q,
  output logic       cout_q,
  output logic       carry_seen
);

  localparam int unsigned W = 4;

  // carry[0] is the tied-off carry-in; carry[W] leaves the chain as cout
  logic [W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    adder_4b_fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[W];

  // Pipeline copy and sticky flag; reset wins over capture in the same cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q      <= '0;
      cout_q     <= 1'b0;
      carry_seen <= 1'b0;
    end else begin
      sum_q      <= sum;
      cout_q     <= cout;
      carry_seen <= carry_seen | cout;
    end
  end

endmodule

// File: tb/tb_adder_4b_struct.sv
// Directed self-checking bench for adder_4b_struct: combinational vectors,
// exhaustive sweep, registered path, sticky flag and reset priority.

module tb_adder_4b_struct;

  logic       clk;
  logic       reset_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sum;
  logic       cout;
  logic [3:0] sum_q;
  logic       cout_q;
  logic       carry_seen;

  int checks;
  int failures;

  adder_4b_struct dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a          (a),
    .b          (b),
    .sum        (sum),
    .cout       (cout),
    .sum_q      (sum_q),
    .cout_q     (cout_q),
    .carry_seen (carry_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive away from the active edge, check 1 time unit after it
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed vectors: a, b, sum, cout
  logic [3:0] va  [9] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd7, 4'd8, 4'd8, 4'd15, 4'd15};
  logic [3:0] vb  [9] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd8, 4'd8, 4'd9, 4'd15, 4'd1};
  logic [3:0] vs  [9] = '{4'd0, 4'd2, 4'd5, 4'd12, 4'd15, 4'd0, 4'd1, 4'd14, 4'd0};
  logic       vc  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    a        = 4'd0;
    b        = 4'd0;

    // Directed combinational vectors (reset held: comb path must ignore it)
    for (int k = 0; k < 9; k++) begin
      a = va[k];
      b = vb[k];
      #1;
      check_eq($sformatf("dir_sum_%0d_%0d", va[k], vb[k]), 8'(sum), 8'(vs[k]));
      check_eq($sformatf("dir_cout_%0d_%0d", va[k], vb[k]), 8'(cout), 8'(vc[k]));
    end

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i);
        b = 4'(j);
        #1;
        check_eq($sformatf("exh_sum_%0d_%0d", i, j), 8'(sum), 8'((i + j) % 16));
        check_eq($sformatf("exh_cout_%0d_%0d", i, j), 8'(cout), 8'((i + j) / 16));
      end
    end

    // Reset for one edge
    @(negedge clk);
    reset_n = 1'b0;
    a = 4'd0;
    b = 4'd0;
    edge_step();
    check_eq("rst_sum_q", 8'(sum_q), 8'd0);
    check_eq("rst_cout_q", 8'(cout_q), 8'd0);
    check_eq("rst_carry_seen", 8'(carry_seen), 8'd0);

    // Release reset, (5,7)
    @(negedge clk);
    reset_n = 1'b1;
    a = 4'd5;
    b = 4'd7;
    edge_step();
    check_eq("reg_5_7_sum_q", 8'(sum_q), 8'd12);
    check_eq("reg_5_7_cout_q", 8'(cout_q), 8'd0);
    check_eq("reg_5_7_carry_seen", 8'(carry_seen), 8'd0);

    // (8,9) sets the sticky flag
    @(negedge clk);
    a = 4'd8;
    b = 4'd9;
    edge_step();
    check_eq("reg_8_9_sum_q", 8'(sum_q), 8'd1);
    check_eq("reg_8_9_cout_q", 8'(cout_q), 8'd1);
    check_eq("reg_8_9_carry_seen", 8'(carry_seen), 8'd1);

    // (1,1) keeps it set across two edges
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    edge_step();
    check_eq("sticky_sum_q", 8'(sum_q), 8'd2);
    check_eq("sticky_cout_q", 8'(cout_q), 8'd0);
    check_eq("sticky_carry_seen_1", 8'(carry_seen), 8'd1);
    edge_step();
    check_eq("sticky_carry_seen_2", 8'(carry_seen), 8'd1);

    // Mid-operation reset clears registers, comb path still tracks inputs
    @(negedge clk);
    reset_n = 1'b0;
    edge_step();
    check_eq("midrst_carry_seen", 8'(carry_seen), 8'd0);
    check_eq("midrst_sum_q", 8'(sum_q), 8'd0);
    check_eq("midrst_sum_comb", 8'(sum), 8'd2);

    // Set flag again with (8,8), then reset in a cycle where cout = 1
    @(negedge clk);
    reset_n = 1'b1;
    a = 4'd8;
    b = 4'd8;
    edge_step();
    check_eq("prio_pre_cout_q", 8'(cout_q), 8'd1);
    check_eq("prio_pre_carry_seen", 8'(carry_seen), 8'd1);
    @(negedge clk);
    reset_n = 1'b0;
    edge_step();
    check_eq("prio_cout_q", 8'(cout_q), 8'd0);
    check_eq("prio_carry_seen", 8'(carry_seen), 8'd0);
    check_eq("prio_sum_q", 8'(sum_q), 8'd0);
    check_eq("prio_cout_comb", 8'(cout), 8'd1);
    check_eq("prio_sum_comb", 8'(sum), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_4b_struct.md
Name: adder_4b_struct

Overview:
- 4-bit unsigned binary adder built structurally as a ripple-carry chain of four gate-level full-adder cells.
- Primary sum output is purely combinational and wraps modulo 16; no carry-in.
- Also provides a carry-out, a registered copy of sum and carry, and a sticky carry flag, all clocked, for pipeline and status use in the datapath.

Parameters:
- none (width fixed at 4 bits)

Ports:
- clk       input   1  system clock; all registered state updates on its rising edge
- reset_n   input   1  synchronous reset, active-low
- a         input   4  addend A, unsigned
- b         input   4  addend B, unsigned
- sum       output  4  combinational (a + b) mod 16
- cout      output  1  combinational carry out of bit 3 (1 when a + b >= 16)
- sum_q     output  4  sum registered on rising clk
- cout_q    output  1  cout registered on rising clk
- carry_seen output 1  sticky flag: set once any registered cycle had cout = 1

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on reset_n. Sampled only at the rising edge of clk.
- Structure:
  - Bit i is a full-adder cell: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - c_0 is tied to 0; cout = c_4.
  - No behavioural "+" operator on the sum path.
- Combinational path:
  - sum and cout depend only on a and b, with zero cycles of latency.
  - They are valid within one simulation time unit of an input change.
  - They are independent of clk and reset_n; reset does not force sum or cout.
- Wrap-around: results >= 16 drop bit 4 from sum and report it on cout. Examples: 8 + 8 gives sum 0, cout 1; 15 + 15 gives sum 14, cout 1.
- Registered path, at each rising clk:
  - If reset_n = 0: sum_q <= 0, cout_q <= 0, carry_seen <= 0.
  - Otherwise: sum_q <= sum, cout_q <= cout, carry_seen <= carry_seen | cout.
- Latency: sum_q and cout_q trail a and b by exactly 1 cycle.
- Reset values:
  - sum_q = 0, cout_q = 0, carry_seen = 0 after the first edge with reset_n low.
  - Registered outputs are X until then; benches must reset first.
- Simultaneous events: reset_n low has priority over capture, even if cout = 1 in that cycle.
- Reset mid-operation: the registered outputs clear on the next edge, and the combinational outputs continue to track a and b.
- carry_seen is cleared only by reset.

Test Plan:
- Simple adds, each checked 1 time unit after the input change:
  - (0,0) -> sum 0
  - (1,1) -> 2
  - (2,3) -> 5
  - (5,7) -> 12
  - (7,8) -> 15
  - all of these with cout 0.
- Overflow adds:
  - (8,8) -> sum 0, cout 1
  - (8,9) -> sum 1, cout 1
  - (15,15) -> sum 14, cout 1
  - (15,1) -> sum 0, cout 1
- Exhaustive check: all 256 (a,b) pairs -> sum == (a+b)&15 and cout == (a+b)>>4.
- Registered path:
  - Hold reset_n low for 1 edge -> sum_q 0, cout_q 0, carry_seen 0.
  - Release reset, apply (5,7) -> after the next edge sum_q 12, cout_q 0, carry_seen 0.
- Sticky flag:
  - Apply (8,9) for one cycle, then (1,1) -> carry_seen 1 and stays 1.
  - Then assert reset_n low for one edge -> carry_seen 0, sum_q 0, while combinational sum still shows 2.
- Reset priority: reset_n low in the same cycle as (8,8) -> cout_q 0 and carry_seen 0 after the edge.
